// File: rtl/ahb2_sram_slave.sv
// AHB2 slave fronting a word-addressed on-chip SRAM.
// Zero-wait OKAY for legal beats, two-cycle ERROR for illegal size/alignment.
module ahb2_sram_slave #(
  parameter int AW = 10
) (
  input  logic        hclk,
  input  logic        hreset_n,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [31:0] hwdata,
  input  logic        hreadyi,
  output logic [31:0] hrdata,
  output logic        hreadyo,
  output logic [1:0]  hresp
);

  typedef enum logic [1:0] {
    ST_OK,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   mem [2**AW];
  logic          samp, acc, legal;
  logic [AW-1:0] a_idx;
  logic [3:0]    a_be;
  logic [31:0]   rd_d, rd_q;
  logic          dp_wr;
  logic [AW-1:0] dp_idx;
  logic [3:0]    dp_be;

  logic unused;
  assign unused = ^{hburst, hprot, haddr[31:AW+2], htrans[0]};

  always_comb begin
    a_idx = haddr[AW+1:2];
    samp  = hreadyi && (state_q != ST_ERR1);
    acc   = samp && hsel && htrans[1];
    legal = 1'b0;
    a_be  = 4'b0000;
    unique case (1'b1)
      (hsize == 3'b000): begin
        legal = 1'b1;
        a_be  = 4'b0001 << haddr[1:0];
      end
      (hsize == 3'b001): begin
        legal = !haddr[0];
        a_be  = haddr[1] ? 4'b1100 : 4'b0011;
      end
      (hsize == 3'b010): begin
        legal = (haddr[1:0] == 2'b00);
        a_be  = 4'b1111;
      end
      default: ;
    endcase
  end

  // read launched in the address phase, bypassing a same-word write
  always_comb begin
    rd_d = mem[a_idx];
    for (int i = 0; i < 4; i++) begin
      if (dp_wr && dp_idx == a_idx && dp_be[i])
        rd_d[8*i +: 8] = hwdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (acc && !legal)
          state_d = ST_ERR1;
        else if (hreadyi)
          state_d = ST_OK;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= ST_OK;
      rd_q    <= '0;
      dp_wr   <= 1'b0;
      dp_idx  <= '0;
      dp_be   <= '0;
    end else begin
      state_q <= state_d;
      if (samp) begin
        rd_q   <= (acc && legal && !hwrite) ? rd_d : '0;
        dp_wr  <= acc && legal && hwrite;
        dp_idx <= a_idx;
        dp_be  <= a_be;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (dp_wr && hreadyi) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i])
          mem[dp_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hrdata  = rd_q;
  assign hreadyo = (state_q != ST_ERR1);
  assign hresp   = {1'b0, state_q != ST_OK};

endmodule

// File: tb/tb_ahb2_sram_slave.sv
// Bench for ahb2_sram_slave: byte-level memory model, expected-response
// queue per data phase, directed scenarios then random traffic.
module tb_ahb2_sram_slave;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BZ = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        hclk = 1'b0;
  logic        hreset_n;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hreadyi;
  logic [31:0] hrdata;
  logic        hreadyo;
  logic [1:0]  hresp;

  ahb2_sram_slave #(.AW(10)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hwdata(hwdata), .hreadyi(hreadyi),
    .hrdata(hrdata), .hreadyo(hreadyo), .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  typedef struct packed {
    logic        own;
    logic        rdy;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mdl [0:127];
  bit          pend_wr;
  int          pend_off;
  int          pend_sz;
  int          total = 0;
  int          bad = 0;
  logic        last_rdy;
  logic [1:0]  last_resp;
  logic [31:0] last_rdata;

  function automatic exp_t mk(input logic o, input logic r,
                              input logic e, input logic [31:0] d);
    exp_t x;
    x.own = o; x.rdy = r; x.err = e; x.data = d;
    return x;
  endfunction

  function automatic logic [31:0] mword(input int off);
    int b;
    b = off & ~3;
    return {mdl[b+3], mdl[b+2], mdl[b+1], mdl[b]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: check the current data phase, then present the next
  // address phase and this data phase's write data.
  task automatic cyc(input bit sel, input logic [1:0] tr, input bit wr,
                     input logic [2:0] sz, input int off, input bit frc,
                     input logic [31:0] wd);
    exp_t e;
    bit   fo, ok;
    @(negedge hclk);
    e = (q.size() > 0) ? q.pop_front() : mk(1'b0, 1'b1, 1'b0, 32'h0);
    last_rdy = hreadyo; last_resp = hresp; last_rdata = hrdata;
    chk("hreadyo", {31'h0, hreadyo}, {31'h0, e.rdy});
    chk("hresp", {30'h0, hresp}, e.err ? 32'h1 : 32'h0);
    chk("hrdata", hrdata, e.data);
    fo = frc && !e.own;
    hwdata = wd;
    if (pend_wr) begin
      for (int k = 0; k < (1 << pend_sz); k++)
        mdl[pend_off+k] = wd[8*((pend_off+k)%4) +: 8];
      pend_wr = 0;
    end
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz;
    haddr  = ($urandom & 32'hFFFF_F000) | 32'(off);
    hburst = 3'($urandom);
    hprot  = 4'($urandom);
    hreadyi = e.rdy && !fo;
    if (hreadyi) begin
      if (sel && tr[1]) begin
        ok = (sz == 0) || (sz == 1 && off % 2 == 0) ||
             (sz == 2 && off % 4 == 0);
        if (!ok) begin
          q.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0));
          q.push_back(mk(1'b1, 1'b1, 1'b1, 32'h0));
        end else if (wr) begin
          q.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0));
          pend_wr = 1; pend_off = off; pend_sz = int'(sz);
        end else begin
          q.push_back(mk(1'b1, 1'b1, 1'b0, mword(off)));
        end
      end else begin
        q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0));
      end
    end
  endtask

  task automatic idle(input logic [31:0] wd);
    cyc(0, ID, 0, 3'd0, 0, 0, wd);
  endtask

  task automatic do_reset(input string tag);
    @(negedge hclk);
    #2 hreset_n = 1'b0;
    #1;
    chk({tag, "_rdy"}, {31'h0, hreadyo}, 32'h1);
    chk({tag, "_resp"}, {30'h0, hresp}, 32'h0);
    chk({tag, "_rdata"}, hrdata, 32'h0);
    hsel = 0; htrans = ID; hreadyi = 1;
    q.delete();
    pend_wr = 0;
    @(negedge hclk);
    @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  initial begin
    hreset_n = 1'b1;
    hsel = 0; haddr = 0; htrans = ID; hwrite = 0; hsize = 0;
    hburst = 0; hprot = 0; hwdata = 0; hreadyi = 1;
    pend_wr = 0;
    #3 hreset_n = 1'b0;
    #1;
    chk("rst_rdy", {31'h0, hreadyo}, 32'h1);
    chk("rst_resp", {30'h0, hresp}, 32'h0);
    chk("rst_rdata", hrdata, 32'h0);
    repeat (2) @(negedge hclk);
    hreset_n = 1'b1;

    for (int i = 0; i < 32; i++)
      cyc(1, i[0] ? SQ : NS, 1, 3'd2, i * 4, 0, $urandom);

    cyc(1, NS, 1, 3'd2, 'h10, 0, $urandom);
    idle(32'hDEADBEEF);
    cyc(1, NS, 0, 3'd2, 'h10, 0, $urandom);
    idle($urandom);
    chk("lit_word", last_rdata, 32'hDEADBEEF);

    cyc(1, NS, 1, 3'd2, 'h20, 0, $urandom);
    cyc(1, NS, 1, 3'd0, 'h21, 0, 32'h0);
    cyc(1, NS, 0, 3'd2, 'h20, 0, 32'h5555AA55);
    cyc(1, NS, 1, 3'd1, 'h22, 0, $urandom);
    chk("lit_byte", last_rdata, 32'h0000AA00);
    cyc(1, NS, 0, 3'd2, 'h20, 0, 32'h12345678);
    idle($urandom);
    chk("lit_half", last_rdata, 32'h1234AA00);

    cyc(1, NS, 1, 3'd2, 'h30, 0, $urandom);
    cyc(1, NS, 0, 3'd2, 'h30, 0, 32'h55667788);
    idle($urandom);
    chk("lit_hazard", last_rdata, 32'h55667788);

    cyc(1, NS, 1, 3'd2, 'h40, 0, $urandom);
    cyc(1, NS, 1, 3'd2, 'h42, 0, 32'hCAFEF00D);
    cyc(1, NS, 1, 3'd2, 'h40, 0, $urandom);
    chk("lit_err1_rdy", {31'h0, last_rdy}, 32'h0);
    chk("lit_err1_resp", {30'h0, last_resp}, 32'h1);
    cyc(1, NS, 0, 3'd2, 'h40, 0, $urandom);
    chk("lit_err2_rdy", {31'h0, last_rdy}, 32'h1);
    chk("lit_err2_resp", {30'h0, last_resp}, 32'h1);
    idle($urandom);
    chk("lit_err_keep", last_rdata, 32'hCAFEF00D);

    cyc(1, NS, 1, 3'd2, 'h48, 0, $urandom);
    cyc(1, NS, 1, 3'd3, 'h48, 0, 32'h0BADC0DE);
    idle($urandom);
    chk("lit_sz3_rdy", {31'h0, last_rdy}, 32'h0);
    cyc(1, NS, 0, 3'd2, 'h48, 0, $urandom);
    idle($urandom);
    chk("lit_sz3_keep", last_rdata, 32'h0BADC0DE);

    cyc(1, ID, 1, 3'd2, 'h10, 0, $urandom);
    cyc(1, BZ, 1, 3'd2, 'h10, 0, $urandom);
    cyc(0, NS, 1, 3'd2, 'h10, 0, $urandom);
    idle($urandom);
    cyc(1, NS, 1, 3'd2, 'h10, 1, $urandom);
    cyc(1, NS, 0, 3'd2, 'h10, 0, $urandom);
    idle($urandom);
    chk("lit_idle_keep", last_rdata, 32'hDEADBEEF);

    cyc(1, NS, 0, 3'd2, 'h10, 0, $urandom);
    do_reset("rst_rd");
    cyc(1, NS, 1, 3'd2, 'h10, 0, $urandom);
    do_reset("rst_wr");
    cyc(1, NS, 1, 3'd1, 'h13, 0, $urandom);
    do_reset("rst_err");
    cyc(1, NS, 0, 3'd2, 'h10, 0, $urandom);
    idle($urandom);
    chk("lit_rst_keep", last_rdata, 32'hDEADBEEF);

    for (int n = 0; n < 3000; n++) begin
      logic [2:0] sz;
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7))
                                        : 3'($urandom_range(0, 2));
      cyc($urandom_range(0, 7) != 0, 2'($urandom), 1'($urandom), sz,
          int'($urandom_range(0, 127)), $urandom_range(0, 15) == 0,
          $urandom);
    end
    repeat (3) idle($urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
